karatsuba_multiplier: RTL and testbench
=======================================

Name: karatsuba_multiplier

Overview:
- Fully pipelined unsigned 256x256 -> 512-bit multiplier using one level of Karatsuba decomposition (three half-width products instead of four).
- Accepts one operand pair per clock. Fixed latency; no backpressure.
- Serves as the wide-product datapath that feeds modular-reduction logic in the modular multiplier.

Parameters:
- WIDTH, 256, operand width in bits. Must be even. Product is 2*WIDTH bits; half width H = WIDTH/2.
- LATENCY, 4, localparam, not overridable. Rising edges from the edge that samples in_valid to the edge that presents P/out_valid, counting the sampling edge.

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  X/Y carry a valid operand pair this cycle.
- X  in  WIDTH  unsigned multiplicand.
- Y  in  WIDTH  unsigned multiplier.
- P  out  2*WIDTH  registered product X*Y.
- out_valid  out  1  registered; P holds a new product this cycle.

Behaviour:
- Reset: on a rising edge with reset=1, P=0, out_valid=0, and all internal stage-valid bits clear. Reset overrides in_valid. Reset mid-operation discards every in-flight pair. No out_valid pulse appears for pairs accepted before reset.
- Stage 1 (edge t, in_valid=1):
  - register xh=X[W-1:H], xl=X[H-1:0], yh, yl.
  - register xs=xh+xl and ys=yh+yl, each H+1 bits with no carry loss.
  - set v1.
- Stage 2:
  - z2 = xh*yh (WIDTH bits).
  - z0 = xl*yl (WIDTH bits).
  - z1 = xs*ys (WIDTH+2 bits).
  - Register all three; v2 = v1.
- Stage 3:
  - zm = z1 - z2 - z0, computed at WIDTH+2 bits. The result is always non-negative and fits in WIDTH+1 bits.
  - Register zm, z2, z0; v3 = v2.
- Stage 4: P = (z2 << WIDTH) + (zm << H) + z0, computed at 2*WIDTH bits. Bits beyond 2*WIDTH are provably zero. Register P; out_valid = v3.
- Timing: a pair sampled at edge t appears on P with out_valid=1 after edge t+3.
- Throughput: one pair per cycle. Back-to-back valid pairs emerge back-to-back, in order.
- Gating:
  - Each stage's data registers load only when that stage's incoming valid is 1; otherwise they hold.
  - out_valid drops to 0 the cycle after the last result.
  - P holds the last product until the next valid result or reset.
- Invalid inputs: X/Y values (including X/unknown) while in_valid=0 must not affect any output.
- in_valid held high with constant X/Y: out_valid stays 1 and P stays constant.
- Operands are unsigned. No overflow case exists, since 2*WIDTH bits holds the full product.

Decomposition:
- Shared package: WIDTH default, derived H, LATENCY=4 constant, and a product-width helper constant (2*WIDTH).
- One natural sub-module, karatsuba_partial_products:
  - holds stage 2;
  - contains three registered unsigned multipliers (H x H, H x H, H+1 x H+1) with a valid passthrough.
- Split/sum logic, middle-term subtraction, and recombination stay in the top.

Test Plan:
- Reset then idle: reset=1 for 2 edges, in_valid=0 -> P=0, out_valid=0 on every cycle.
- Single small pair: X=3, Y=5, in_valid pulsed for 1 cycle -> exactly one out_valid cycle, 4 edges after sampling, P=15; then out_valid=0 and P holds 15.
- Half-boundary carry: X=2^128, Y=2^128 -> P=2^256. Separately, X=Y=2^256-1 -> P[511:256]=2^256-2, P[255:0]=1; this exercises the 129-bit sums and the middle term.
- Top bits: X=Y=2^255 -> P=2^510. Separately, X=0, Y=2^256-1 -> P=0.
- Back-to-back streaming: 8 consecutive random 256-bit pairs, then a 1-cycle gap, then 3 more -> 11 results in order with matching gap, each equal to a reference big-integer product; out_valid pattern equals the in_valid pattern delayed by 4 edges.
- Reset mid-flight: accept 2 pairs, assert reset 2 cycles later for 1 edge -> no out_valid for those pairs, P=0. A pair sent after reset releases produces the correct product at latency 4.

Source files
------------

// File: rtl/karatsuba_multiplier_pkg.sv
// Shared constants for the Karatsuba wide-product datapath: default operand
// width, derived half/product widths and the fixed pipeline depth.
package karatsuba_multiplier_pkg;

   localparam int WIDTH_DEF  = 256;
   localparam int H_DEF      = WIDTH_DEF / 2;
   localparam int PROD_W_DEF = 2 * WIDTH_DEF;
   localparam int LATENCY    = 4;

   // One valid bit per register stage, oldest stage in the MSB.
   typedef logic [LATENCY-1:0] stage_vld_t;

   function automatic int half_width(input int w);
      return w / 2;
   endfunction

   function automatic int prod_width(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/karatsuba_multiplier_partial_products.sv
// Registered half-width products of one Karatsuba level: hi*hi, lo*lo and
// (hi+lo)*(hi+lo), with the stage valid carried alongside.
module karatsuba_partial_products
   import karatsuba_multiplier_pkg::*;
#(
   parameter int H = H_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             vld_p1,
   input  logic [H-1:0]     xh_p1,
   input  logic [H-1:0]     xl_p1,
   input  logic [H-1:0]     yh_p1,
   input  logic [H-1:0]     yl_p1,
   input  logic [H:0]       xs_p1,
   input  logic [H:0]       ys_p1,
   output logic [2*H-1:0]   z2_p2,
   output logic [2*H-1:0]   z0_p2,
   output logic [2*H+1:0]   z1_p2,
   output logic             vld_p2
);

   localparam int ZHW = 2 * H;
   localparam int ZSW = 2 * H + 2;

   // Stage 2: three independent multipliers, operands widened to product width
   always_ff @(posedge clock) begin
      if (vld_p1) begin
         z2_p2 <= ZHW'(xh_p1) * ZHW'(yh_p1);
         z0_p2 <= ZHW'(xl_p1) * ZHW'(yl_p1);
         z1_p2 <= ZSW'(xs_p1) * ZSW'(ys_p1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) vld_p2 <= 1'b0;
      else       vld_p2 <= vld_p1;
   end

endmodule

// File: rtl/karatsuba_multiplier.sv
// Fully pipelined unsigned WIDTH x WIDTH multiplier, one Karatsuba level,
// one operand pair per clock, fixed four-edge latency. WIDTH must be even.
module karatsuba_multiplier
   import karatsuba_multiplier_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            in_valid,
   input  logic [WIDTH-1:0]                X,
   input  logic [WIDTH-1:0]                Y,
   output logic [prod_width(WIDTH)-1:0]    P,
   output logic                            out_valid
);

   localparam int H  = half_width(WIDTH);
   localparam int PW = prod_width(WIDTH);
   localparam int ZW = WIDTH + 2;

   // z1 >= z2 + z0 always, so the difference never wraps at ZW bits.
   function automatic logic [ZW-1:0] mid_term(input logic [ZW-1:0]    z1,
                                              input logic [WIDTH-1:0] z2,
                                              input logic [WIDTH-1:0] z0);
      return z1 - ZW'(z2) - ZW'(z0);
   endfunction

   function automatic logic [PW-1:0] recombine(input logic [WIDTH-1:0] z2,
                                               input logic [ZW-1:0]    zm,
                                               input logic [WIDTH-1:0] z0);
      return {z2, {WIDTH{1'b0}}} + (PW'(zm) << H) + PW'(z0);
   endfunction

   logic [H-1:0]     xh_p1, xl_p1, yh_p1, yl_p1;
   logic [H:0]       xs_p1, ys_p1;
   logic             vld_p1;

   logic [WIDTH-1:0] z2_p2, z0_p2;
   logic [ZW-1:0]    z1_p2;
   logic             vld_p2;

   logic [WIDTH-1:0] z2_p3, z0_p3;
   logic [ZW-1:0]    zm_p3;
   logic             vld_p3;

   // Stage 1: split operands and form the carry-preserving half sums
   always_ff @(posedge clock) begin
      if (in_valid) begin
         xh_p1 <= X[WIDTH-1:H];
         xl_p1 <= X[H-1:0];
         yh_p1 <= Y[WIDTH-1:H];
         yl_p1 <= Y[H-1:0];
         xs_p1 <= {1'b0, X[WIDTH-1:H]} + {1'b0, X[H-1:0]};
         ys_p1 <= {1'b0, Y[WIDTH-1:H]} + {1'b0, Y[H-1:0]};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) vld_p1 <= 1'b0;
      else       vld_p1 <= in_valid;
   end

   // Stage 2: half-width products
   karatsuba_partial_products #(
      .H (H)
   ) u_partial_products (
      .clock  (clock),
      .reset  (reset),
      .vld_p1 (vld_p1),
      .xh_p1  (xh_p1),
      .xl_p1  (xl_p1),
      .yh_p1  (yh_p1),
      .yl_p1  (yl_p1),
      .xs_p1  (xs_p1),
      .ys_p1  (ys_p1),
      .z2_p2  (z2_p2),
      .z0_p2  (z0_p2),
      .z1_p2  (z1_p2),
      .vld_p2 (vld_p2)
   );

   // Stage 3: middle term
   always_ff @(posedge clock) begin
      if (vld_p2) begin
         zm_p3 <= mid_term(z1_p2, z2_p2, z0_p2);
         z2_p3 <= z2_p2;
         z0_p3 <= z0_p2;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) vld_p3 <= 1'b0;
      else       vld_p3 <= vld_p2;
   end

   // Stage 4: recombination; P is cleared by reset and otherwise holds
   always_ff @(posedge clock) begin
      if (reset) begin
         P         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= vld_p3;
         if (vld_p3) P <= recombine(z2_p3, zm_p3, z0_p3);
      end
   end

endmodule

// File: tb/tb_karatsuba_multiplier.sv
// Directed bench for karatsuba_multiplier: table of hand-computed products,
// plus streaming, held-valid and mid-flight reset sequences.
module tb_karatsuba_multiplier;
   import karatsuba_multiplier_pkg::*;

   localparam int W  = WIDTH_DEF;
   localparam int PW = PROD_W_DEF;
   localparam int H  = H_DEF;

   typedef struct {
      string           name;
      logic [W-1:0]    x;
      logic [W-1:0]    y;
      logic [PW-1:0]   p;
   } vec_t;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            in_valid = 1'b0;
   logic [W-1:0]    X = '0;
   logic [W-1:0]    Y = '0;
   logic [PW-1:0]   P;
   logic            out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   karatsuba_multiplier #(
      .WIDTH (W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .X         (X),
      .Y         (Y),
      .P         (P),
      .out_valid (out_valid)
   );

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Schoolbook reference product on 32-bit limbs.
   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [PW-1:0] r;
      logic [63:0]   t;
      logic [63:0]   carry;
      r = '0;
      for (int i = 0; i < W / 32; i++) begin
         carry = '0;
         for (int j = 0; j < W / 32; j++) begin
            t = {32'b0, a[i*32 +: 32]} * {32'b0, b[j*32 +: 32]}
                + {32'b0, r[(i+j)*32 +: 32]} + carry;
            r[(i+j)*32 +: 32] = t[31:0];
            carry = {32'b0, t[63:32]};
         end
         r[(i + W/32)*32 +: 32] = carry[31:0];
      end
      return r;
   endfunction

   task automatic run_single(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [PW-1:0] exp);
      int pulses;
      int first;
      pulses = 0;
      first  = 0;
      @(negedge clock);
      in_valid = 1'b1;
      X = x;
      Y = y;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clock);
         #1;
         if (out_valid) begin
            pulses++;
            if (first == 0) begin
               first = k;
               check({name, " P"}, P, exp);
            end
         end
         if (k == 1) begin
            in_valid = 1'b0;
            X = rand_w();
            Y = rand_w();
         end
      end
      check({name, " latency"}, PW'(first), PW'(LATENCY));
      check({name, " pulses"}, PW'(pulses), PW'(1));
      check({name, " hold P"}, P, exp);
      check({name, " idle out_valid"}, PW'(out_valid), PW'(0));
   endtask

   vec_t          vecs [8];
   logic [W-1:0]  ones;
   logic [W-1:0]  sx [12];
   logic [W-1:0]  sy [12];
   logic [PW-1:0] sref [12];
   logic          pat [12];

   initial begin
      ones = '1;
      vecs[0] = '{"small",       W'(3),            W'(5),            PW'(15)};
      vecs[1] = '{"half_carry",  W'(1) << H,       W'(1) << H,       PW'(1) << W};
      vecs[2] = '{"all_ones",    ones,             ones,             {ones - W'(1), W'(1)}};
      vecs[3] = '{"top_bit",     W'(1) << (W-1),   W'(1) << (W-1),   PW'(1) << (PW-2)};
      vecs[4] = '{"zero_x",      W'(0),            ones,             PW'(0)};
      vecs[5] = '{"one_x_max",   W'(1),            ones,             PW'(ones)};
      vecs[6] = '{"max_x_two",   ones,             W'(2),            PW'(ones) << 1};
      vecs[7] = '{"lo_half_ones", (W'(1) << H) - W'(1), (W'(1) << H) - W'(1),
                  (PW'(1) << W) - (PW'(1) << (H+1)) + PW'(1)};

      // Reset then idle
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         #1;
         check("reset P", P, PW'(0));
         check("reset out_valid", PW'(out_valid), PW'(0));
      end
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         check("idle P", P, PW'(0));
         check("idle out_valid", PW'(out_valid), PW'(0));
      end

      for (int i = 0; i < 8; i++) run_single(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].p);

      // Streaming: 8 pairs, one-cycle gap, 3 pairs
      for (int i = 0; i < 12; i++) begin
         sx[i]   = rand_w();
         sy[i]   = rand_w();
         pat[i]  = (i != 8);
         sref[i] = ref_mul(sx[i], sy[i]);
      end
      for (int c = 0; c < 18; c++) begin
         @(negedge clock);
         if (c < 12) begin
            in_valid = pat[c];
            X = sx[c];
            Y = sy[c];
         end else begin
            in_valid = 1'b0;
            X = rand_w();
            Y = rand_w();
         end
         @(posedge clock);
         #1;
         if (c >= 3 && c - 3 < 12 && pat[c-3]) begin
            check("stream out_valid", PW'(out_valid), PW'(1));
            check("stream P", P, sref[c-3]);
         end else begin
            check("stream out_valid", PW'(out_valid), PW'(0));
            if (c - 3 == 8) check("stream gap hold P", P, sref[7]);
         end
      end

      // Held valid with constant operands
      sx[0] = rand_w();
      sy[0] = rand_w();
      sref[0] = ref_mul(sx[0], sy[0]);
      @(negedge clock);
      in_valid = 1'b1;
      X = sx[0];
      Y = sy[0];
      for (int c = 0; c < 8; c++) begin
         @(posedge clock);
         #1;
         if (c >= 3) begin
            check("held out_valid", PW'(out_valid), PW'(1));
            check("held P", P, sref[0]);
         end
      end
      @(negedge clock);
      in_valid = 1'b0;
      repeat (5) @(negedge clock);

      // Reset mid-flight: two pairs accepted, reset two cycles later
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         in_valid = (c < 2);
         X = rand_w();
         Y = rand_w();
         reset = (c == 3);
         @(posedge clock);
         #1;
         check("flight out_valid", PW'(out_valid), PW'(0));
         if (c >= 3) check("flight P", P, PW'(0));
      end
      @(negedge clock);
      reset = 1'b0;
      sx[1] = rand_w();
      sy[1] = rand_w();
      run_single("post_reset", sx[1], sy[1], ref_mul(sx[1], sy[1]));

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
